// File: rtl/arp_cache.sv
// arp_cache: small associative table of learned IP-to-MAC mappings.
// Entries are learned from the ARP receive stage and aged out by a timer strobe.
// When the table is full, entries are replaced round-robin.
// IP lookups resolve with a fixed two-cycle latency.
module arp_cache #(
  parameter int ENTRIES = 4,
  parameter int AGEBITS = 8,
  parameter int MAXAGE  = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       learnvalid,
  input  logic [47:0]                learnhwaddr,
  input  logic [31:0]                learnipaddr,
  input  logic                       agetick,
  input  logic                       lookupvalid,
  input  logic [31:0]                lookupipaddr,
  output logic                       lookupready,
  output logic                       lookupdone,
  output logic                       lookuphit,
  output logic [47:0]                lookuphwaddr,
  output logic [$clog2(ENTRIES):0]   entrycount
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int CNTW = IDXW + 1;
  localparam logic [AGEBITS-1:0] MAXAGE_C = AGEBITS'(MAXAGE);

  typedef enum logic [0:0] {IDLE = 1'b0, RESULT = 1'b1} lk_state_t;

  // table storage
  logic                valid_r [ENTRIES];
  logic [31:0]         ip_r    [ENTRIES];
  logic [47:0]         hw_r    [ENTRIES];
  logic [AGEBITS-1:0]  age_r   [ENTRIES];
  logic [IDXW-1:0]     victim_r;

  // next-state table image
  logic                valid_n [ENTRIES];
  logic [31:0]         ip_n    [ENTRIES];
  logic [47:0]         hw_n    [ENTRIES];
  logic [AGEBITS-1:0]  age_n   [ENTRIES];
  logic [IDXW-1:0]     victim_n;
  logic [CNTW-1:0]     count_n;

  // learn slot selection
  logic                learn_en_s;
  logic                match_found_s;
  logic [IDXW-1:0]     match_idx_s;
  logic                free_found_s;
  logic [IDXW-1:0]     free_idx_s;
  logic [IDXW-1:0]     learn_slot_s;

  // lookup path
  lk_state_t           state_r;
  logic [31:0]         lkip_r;
  logic                lk_hit_s;
  logic [47:0]         lk_hw_s;

  // Pick the slot a learn writes: existing IP first, then the lowest free slot, else the victim.
  always_comb begin
    learn_en_s    = learnvalid && (learnipaddr != 32'd0);
    match_found_s = 1'b0;
    match_idx_s   = '0;
    free_found_s  = 1'b0;
    free_idx_s    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_r[i] && (ip_r[i] == learnipaddr)) begin
        match_found_s = 1'b1;
        match_idx_s   = IDXW'(i);
      end else begin
        match_found_s = match_found_s;
      end
    end
    // Scan downward so the last assignment is the lowest free index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDXW'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
    if (match_found_s) begin
      learn_slot_s = match_idx_s;
    end else if (free_found_s) begin
      learn_slot_s = free_idx_s;
    end else begin
      learn_slot_s = victim_r;
    end
  end

  // Build the post-edge table: age every slot, then let a learn override its slot.
  always_comb begin
    victim_n = victim_r;
    count_n  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_n[i] = valid_r[i];
      ip_n[i]    = ip_r[i];
      hw_n[i]    = hw_r[i];
      age_n[i]   = age_r[i];
      if (agetick && valid_r[i] && (age_r[i] != '0)) begin
        age_n[i] = age_r[i] - AGEBITS'(1);
        if (age_r[i] == AGEBITS'(1)) begin
          valid_n[i] = 1'b0;
        end else begin
          valid_n[i] = valid_r[i];
        end
      end else begin
        age_n[i] = age_r[i];
      end
      if (learn_en_s && (learn_slot_s == IDXW'(i))) begin
        valid_n[i] = 1'b1;
        ip_n[i]    = learnipaddr;
        hw_n[i]    = learnhwaddr;
        age_n[i]   = MAXAGE_C;
      end else begin
        valid_n[i] = valid_n[i];
      end
      count_n = count_n + {{IDXW{1'b0}}, valid_n[i]};
    end
    // The pointer advances only when a full table forces an eviction.
    if (learn_en_s && !match_found_s && !free_found_s) begin
      victim_n = victim_r + IDXW'(1);
    end else begin
      victim_n = victim_r;
    end
  end

  // Resolve the registered lookup IP against the current table; IP 0 never matches.
  always_comb begin
    lk_hit_s = 1'b0;
    lk_hw_s  = 48'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_r[i] && (ip_r[i] == lkip_r) && (lkip_r != 32'd0)) begin
        lk_hit_s = 1'b1;
        lk_hw_s  = hw_r[i];
      end else begin
        lk_hit_s = lk_hit_s;
      end
    end
  end

  // Table state register, victim pointer and registered entry count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ip_r[i]    <= 32'd0;
        hw_r[i]    <= 48'd0;
        age_r[i]   <= '0;
      end
      victim_r   <= '0;
      entrycount <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= valid_n[i];
        ip_r[i]    <= ip_n[i];
        hw_r[i]    <= hw_n[i];
        age_r[i]   <= age_n[i];
      end
      victim_r   <= victim_n;
      entrycount <= count_n;
    end
  end

  // Lookup controller: accept a request in IDLE, publish the result from RESULT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      lkip_r       <= 32'd0;
      lookupready  <= 1'b1;
      lookupdone   <= 1'b0;
      lookuphit    <= 1'b0;
      lookuphwaddr <= 48'd0;
    end else begin
      case (state_r)
        IDLE: begin
          lookupdone <= 1'b0;
          if (lookupvalid) begin
            lkip_r      <= lookupipaddr;
            state_r     <= RESULT;
            lookupready <= 1'b0;
          end else begin
            lookupready <= 1'b1;
          end
        end
        RESULT: begin
          lookupdone   <= 1'b1;
          lookuphit    <= lk_hit_s;
          lookuphwaddr <= lk_hw_s;
          lookupready  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          lookupready <= 1'b1;
          lookupdone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_cache.sv
// Directed bench for arp_cache (ENTRIES=4, MAXAGE=3) with hand-computed expectations.
module tb_arp_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        learnvalid;
  logic [47:0] learnhwaddr;
  logic [31:0] learnipaddr;
  logic        agetick;
  logic        lookupvalid;
  logic [31:0] lookupipaddr;
  logic        lookupready;
  logic        lookupdone;
  logic        lookuphit;
  logic [47:0] lookuphwaddr;
  logic [2:0]  entrycount;

  int checks   = 0;
  int failures = 0;

  arp_cache #(.ENTRIES(4), .AGEBITS(8), .MAXAGE(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .learnvalid   (learnvalid),
    .learnhwaddr  (learnhwaddr),
    .learnipaddr  (learnipaddr),
    .agetick      (agetick),
    .lookupvalid  (lookupvalid),
    .lookupipaddr (lookupipaddr),
    .lookupready  (lookupready),
    .lookupdone   (lookupdone),
    .lookuphit    (lookuphit),
    .lookuphwaddr (lookuphwaddr),
    .entrycount   (entrycount)
  );

  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] hw, input logic tick);
    learnvalid  = 1'b1;
    learnipaddr = ip;
    learnhwaddr = hw;
    agetick     = tick;
    step();
    learnvalid  = 1'b0;
    agetick     = 1'b0;
  endtask

  task automatic age_tick();
    agetick = 1'b1;
    step();
    agetick = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] ip,
                           input logic exp_hit, input logic [47:0] exp_hw);
    check_val({tag, "_rdy"}, 64'(lookupready), 64'd1);
    lookupvalid  = 1'b1;
    lookupipaddr = ip;
    step();
    lookupvalid  = 1'b0;
    check_val({tag, "_busy"}, {62'd0, lookupready, lookupdone}, 64'd0);
    step();
    check_val({tag, "_done"}, 64'(lookupdone), 64'd1);
    check_val({tag, "_hit"},  64'(lookuphit), 64'(exp_hit));
    check_val({tag, "_hw"},   64'(lookuphwaddr), 64'(exp_hw));
  endtask

  function automatic logic [47:0] mac_of(input logic [31:0] ip);
    return 48'h0200_0000_0000 | {16'd0, ip};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; learnvalid = 1'b0; learnhwaddr = 48'd0; learnipaddr = 32'd0;
    agetick = 1'b0; lookupvalid = 1'b0; lookupipaddr = 32'd0;
    do_reset();
    check_val("rst_ready", 64'(lookupready), 64'd1);
    check_val("rst_outs", {lookupdone, lookuphit, lookuphwaddr, entrycount}, 64'd0);

    // 1: basic learn and hit
    learn(32'h0A00_0001, 48'h0011_2233_4455, 1'b0);
    check_val("t1_count", 64'(entrycount), 64'd1);
    do_lookup("t1_lk", 32'h0A00_0001, 1'b1, 48'h0011_2233_4455);
    step();
    check_val("t1_done_pulse", 64'(lookupdone), 64'd0);
    check_val("t1_hold_hw", 64'(lookuphwaddr), 64'h0011_2233_4455);

    // 2: refresh same IP, then unknown IP
    learn(32'h0A00_0001, 48'hAABB_CCDD_EEFF, 1'b0);
    check_val("t2_count", 64'(entrycount), 64'd1);
    do_lookup("t2_lk", 32'h0A00_0001, 1'b1, 48'hAABB_CCDD_EEFF);
    do_lookup("t2_miss", 32'h0A00_0009, 1'b0, 48'd0);
    // A learn during RESULT is invisible to that comparison, visible to the next.
    lookupvalid = 1'b1; lookupipaddr = 32'h0A00_0009;
    step();
    lookupvalid = 1'b0;
    learn(32'h0A00_0009, 48'h0000_0000_0909, 1'b0);
    check_val("t2_race_hit", {62'd0, lookupdone, lookuphit}, 64'd2);
    do_lookup("t2_after", 32'h0A00_0009, 1'b1, 48'h0000_0000_0909);

    // 3: fill and evict round-robin
    do_reset();
    for (int i = 1; i <= 4; i++) learn(32'(i), mac_of(32'(i)), 1'b0);
    check_val("t3_full", 64'(entrycount), 64'd4);
    learn(32'd5, mac_of(32'd5), 1'b0);
    check_val("t3_count5", 64'(entrycount), 64'd4);
    do_lookup("t3_ip1", 32'd1, 1'b0, 48'd0);
    learn(32'd6, mac_of(32'd6), 1'b0);
    do_lookup("t3_ip2", 32'd2, 1'b0, 48'd0);
    do_lookup("t3_ip5", 32'd5, 1'b1, mac_of(32'd5));
    do_lookup("t3_ip6", 32'd6, 1'b1, mac_of(32'd6));
    do_lookup("t3_ip3", 32'd3, 1'b1, mac_of(32'd3));

    // 4: aging with MAXAGE=3
    do_reset();
    learn(32'd7, mac_of(32'd7), 1'b0);
    age_tick();
    check_val("t4_tick1", 64'(entrycount), 64'd1);
    age_tick();
    check_val("t4_tick2", 64'(entrycount), 64'd1);
    age_tick();
    check_val("t4_tick3", 64'(entrycount), 64'd0);
    do_lookup("t4_expired", 32'd7, 1'b0, 48'd0);
    learn(32'd7, mac_of(32'd7), 1'b0);
    age_tick();
    age_tick();
    learn(32'd7, mac_of(32'd7), 1'b1);
    check_val("t4_refresh", 64'(entrycount), 64'd1);
    age_tick();
    age_tick();
    check_val("t4_age3_a", 64'(entrycount), 64'd1);
    age_tick();
    check_val("t4_age3_b", 64'(entrycount), 64'd0);

    // 4b: full table, learn together with mass expiry evicts the victim slot
    do_reset();
    for (int i = 1; i <= 4; i++) learn(32'(i), mac_of(32'(i)), 1'b0);
    age_tick();
    age_tick();
    learn(32'd8, mac_of(32'd8), 1'b1);
    check_val("t4b_count", 64'(entrycount), 64'd1);
    do_lookup("t4b_ip8", 32'd8, 1'b1, mac_of(32'd8));
    for (int i = 9; i <= 11; i++) learn(32'(i), mac_of(32'(i)), 1'b0);
    check_val("t4b_full", 64'(entrycount), 64'd4);
    learn(32'd12, mac_of(32'd12), 1'b0);
    do_lookup("t4b_ip9", 32'd9, 1'b0, 48'd0);
    do_lookup("t4b_ip8b", 32'd8, 1'b1, mac_of(32'd8));

    // 5: IP 0 is never learned or matched
    learn(32'd0, 48'h1234_5678_9ABC, 1'b0);
    check_val("t5_count", 64'(entrycount), 64'd4);
    do_lookup("t5_ip0", 32'd0, 1'b0, 48'd0);

    // 6: reset in the middle of a lookup
    lookupvalid = 1'b1; lookupipaddr = 32'd8;
    step();
    lookupvalid = 1'b0;
    reset = 1'b1;
    step();
    check_val("t6_ready", 64'(lookupready), 64'd1);
    check_val("t6_outs", {lookupdone, lookuphit, lookuphwaddr, entrycount}, 64'd0);
    reset = 1'b0;
    step();
    check_val("t6_nodone", 64'(lookupdone), 64'd0);
    do_lookup("t6_empty", 32'd8, 1'b0, 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
